// File: rtl/msgpass_raddr_gen_mc_pkg.sv
// msgpass_raddr_gen_mc_pkg: shared widths, memShare DRC indices and FSM state type for the read-address generator
package msgPass_config_pkg;
  localparam int MSGPASS_BUFF_ADDR_WIDTH = 10;
  localparam int OFFSET_WIDTH = 8;
  localparam int MEMSHARE_DRC0 = 0;
  localparam int MEMSHARE_DRC1 = 1;
  localparam int MEMSHARE_DRC_NUM = 2;
  typedef enum logic [1:0] {IDLE, RUN, STALL} raddr_state_t;
endpackage

// File: rtl/msgpass_raddr_gen_mc_chan.sv
// msgpass_raddr_chan: one channel's base register, base+offset adder and registered address (carry out with MSGPASS_RADDR_BOUND_CHK_EN)
module msgpass_raddr_chan import msgPass_config_pkg::*; #(
  parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
  parameter int OFFSET_WIDTH = msgPass_config_pkg::OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    adv,
  input  logic [ADDR_WIDTH-1:0]   base_in,
  input  logic [OFFSET_WIDTH-1:0] off,
  output logic [ADDR_WIDTH-1:0]   addr
`ifdef MSGPASS_RADDR_BOUND_CHK_EN
  ,
  output logic                    carry
`endif
);
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] sum;
`ifdef MSGPASS_RADDR_BOUND_CHK_EN
  assign {carry, sum} = {1'b0, base_r} + (ADDR_WIDTH+1)'(off);
`else
  assign sum = base_r + ADDR_WIDTH'(off);
`endif
  // start latches a new base and presents it at offset 0; each advance loads base + next offset
  always_ff @(posedge clk)
    if (rst) begin
      base_r <= '0;
      addr <= '0;
    end else if (load) begin
      base_r <= base_in;
      addr <= base_in;
    end else if (adv) addr <= sum;
endmodule

// File: rtl/msgpass_raddr_gen_mc.sv
// msgpass_raddr_gen_mc: multi-channel message-pass read-address generator; MSGPASS_RADDR_BOUND_CHK_EN enables the sticky address-carry error
module msgpass_raddr_gen_mc import msgPass_config_pkg::*; #(
  parameter int CH_NUM = 4,
  parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
  parameter int OFFSET_WIDTH = msgPass_config_pkg::OFFSET_WIDTH,
  parameter int DRC_NUM = MEMSHARE_DRC_NUM
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         end_i,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] base_addr_i,
  input  logic [OFFSET_WIDTH-1:0]      len_i,
  input  logic [DRC_NUM-1:0]           is_drc_i,
  input  logic [OFFSET_WIDTH-1:0]      drc_offset_i,
  input  logic                         rdy_i,
  output logic [CH_NUM*ADDR_WIDTH-1:0] addr_o,
  output logic                         valid_o,
  output logic                         wrap_o,
  output logic                         err_o
);
  raddr_state_t state, state_n;
  logic [OFFSET_WIDTH-1:0] offset, off_next, len_r;
  logic [OFFSET_WIDTH:0] eff_len, off_inc;
  logic drc_sel, wrap_n, adv;
  logic unused_drc;
  assign unused_drc = ^is_drc_i;
  assign eff_len = {len_r == '0, len_r};
  assign off_inc = {1'b0, offset} + (OFFSET_WIDTH+1)'(1);
  assign drc_sel = state == RUN && is_drc_i[MEMSHARE_DRC1];
  assign wrap_n = drc_sel ? {1'b0, drc_offset_i} >= eff_len : off_inc == eff_len;
  assign off_next = wrap_n ? '0 : drc_sel ? drc_offset_i : off_inc[OFFSET_WIDTH-1:0];
  assign adv = state != IDLE && !start_i && !end_i && valid_o && rdy_i;
  // next state: start restarts from any state, end stops an active run, rdy_i moves between RUN and STALL
  always_comb begin
    state_n = state;
    if (start_i) state_n = RUN;
    else if (state != IDLE && end_i) state_n = IDLE;
    else if (state == RUN && valid_o && !rdy_i) state_n = STALL;
    else if (state == STALL && rdy_i) state_n = RUN;
  end
  // shared state, offset, length and handshake outputs
  always_ff @(posedge sys_clk)
    if (rst) begin
      state <= IDLE;
      offset <= '0;
      len_r <= '0;
      valid_o <= 1'b0;
      wrap_o <= 1'b0;
    end else begin
      state <= state_n;
      valid_o <= start_i || (valid_o && !end_i);
      wrap_o <= adv && wrap_n;
      if (start_i) begin
        offset <= '0;
        len_r <= len_i;
      end else if (adv) offset <= off_next;
    end
`ifdef MSGPASS_RADDR_BOUND_CHK_EN
  logic [CH_NUM-1:0] carry;
  // any channel overflowing its address space latches an error until restart
  always_ff @(posedge sys_clk)
    if (rst || start_i) err_o <= 1'b0;
    else if (adv && |carry) err_o <= 1'b1;
`else
  assign err_o = 1'b0;
`endif
  for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
    msgpass_raddr_chan #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_chan (
      .clk(sys_clk),
      .rst(rst),
      .load(start_i),
      .adv(adv),
      .base_in(base_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .off(off_next),
      .addr(addr_o[c*ADDR_WIDTH +: ADDR_WIDTH])
`ifdef MSGPASS_RADDR_BOUND_CHK_EN
      ,
      .carry(carry[c])
`endif
    );
  end
endmodule
